// File: rtl/arc4_encrypt_if.sv
// Start handshake, key and the plaintext/ciphertext memory ports of arc4_encrypt.
// Latency: none, this is wiring only.
// Backpressure: none; the encryptor drives the memory ports and the memories never stall.
interface arc4_encrypt_if;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  pt_addr;
   logic [7:0]  pt_rddata;
   logic [7:0]  ct_addr;
   logic [7:0]  ct_wrdata;
   logic        ct_wren;

   // encryptor side: reads pt memory, writes ct memory
   modport master (
      input  en, key, pt_rddata,
      output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
   );

   // requester / memory side
   modport slave (
      output en, key, pt_rddata,
      input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren
   );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed message from pt memory and writes the ciphertext to ct memory.
// Latency: 514 + 2*L cycles from the accepting edge until rdy returns high.
// Backpressure: en is sampled only while rdy=1; the memory ports never stall.
module arc4_encrypt (
   input  logic           clk,
   input  logic           rst_n,
   arc4_encrypt_if.master bus
);
   typedef enum logic [2:0] {IDLE, INIT, KSA, LEN_REQ, LEN_WR, BYTE_REQ, BYTE_WR} state_t;

   state_t      state, state_nxt;
   logic [7:0]  s_mem [256];
   logic [7:0]  i_q, j_q, len_q;
   logic [8:0]  k_q;
   logic [1:0]  kidx_q;           // i mod 3 during key scheduling
   logic [23:0] key_q;

   logic [7:0]  key_byte, ksa_j;
   logic [7:0]  i_inc, prga_j, s_i, s_j, pad_idx, pad;
   logic        rdy_c, wren_c;
   logic [7:0]  pt_addr_c, ct_addr_c, ct_wrdata_c;

   // Datapath: KSA j update, and a single-cycle PRGA step with the pad read through the pending swap
   always_comb begin
      key_byte = (kidx_q == 2'd0) ? key_q[23:16] :
                 (kidx_q == 2'd1) ? key_q[15:8]  : key_q[7:0];
      ksa_j    = j_q + s_mem[i_q] + key_byte;
      i_inc    = i_q + 8'd1;
      s_i      = s_mem[i_inc];
      prga_j   = j_q + s_i;
      s_j      = s_mem[prga_j];
      pad_idx  = s_i + s_j;
      // After the swap S[i] holds s_j and S[j] holds s_i; every other entry is unchanged.
      if (pad_idx == i_inc)
         pad = s_j;
      else if (pad_idx == prga_j)
         pad = s_i;
      else
         pad = s_mem[pad_idx];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and memory-port outputs; outputs decode from state so reset clears them at once
   always_comb begin
      state_nxt   = state;
      rdy_c       = 1'b0;
      pt_addr_c   = 8'd0;
      ct_addr_c   = 8'd0;
      ct_wrdata_c = 8'd0;
      wren_c      = 1'b0;
      case (state)
         IDLE: begin
            rdy_c = 1'b1;
            if (bus.en)
               state_nxt = INIT;
         end
         INIT: begin
            if (i_q == 8'hFF)
               state_nxt = KSA;
         end
         KSA: begin
            if (i_q == 8'hFF)
               state_nxt = LEN_REQ;
         end
         LEN_REQ: begin
            pt_addr_c = 8'd0;
            state_nxt = LEN_WR;
         end
         LEN_WR: begin
            wren_c      = 1'b1;
            ct_addr_c   = 8'd0;
            ct_wrdata_c = bus.pt_rddata;
            state_nxt   = (bus.pt_rddata == 8'd0) ? IDLE : BYTE_REQ;
         end
         BYTE_REQ: begin
            pt_addr_c = k_q[7:0];
            state_nxt = BYTE_WR;
         end
         BYTE_WR: begin
            wren_c      = 1'b1;
            ct_addr_c   = k_q[7:0];
            ct_wrdata_c = bus.pt_rddata ^ pad;
            state_nxt   = (k_q == {1'b0, len_q}) ? IDLE : BYTE_REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.rdy       = rdy_c;
   assign bus.pt_addr   = pt_addr_c;
   assign bus.ct_addr   = ct_addr_c;
   assign bus.ct_wrdata = ct_wrdata_c;
   assign bus.ct_wren   = wren_c;

   // Index, key and length registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q    <= 8'd0;
         j_q    <= 8'd0;
         k_q    <= 9'd0;
         len_q  <= 8'd0;
         kidx_q <= 2'd0;
         key_q  <= 24'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.en) begin
                  key_q  <= bus.key;
                  i_q    <= 8'd0;
                  j_q    <= 8'd0;
                  kidx_q <= 2'd0;
               end
            end
            INIT: i_q <= i_q + 8'd1;   // wraps to 0 for the start of KSA
            KSA: begin
               i_q    <= i_q + 8'd1;
               j_q    <= ksa_j;
               kidx_q <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
            end
            LEN_REQ: begin
               i_q <= 8'd0;
               j_q <= 8'd0;
            end
            LEN_WR: begin
               len_q <= bus.pt_rddata;
               k_q   <= 9'd1;
            end
            BYTE_WR: begin
               i_q <= i_inc;
               j_q <= prga_j;
               k_q <= k_q + 9'd1;
            end
            default: ;
         endcase
      end
   end

   // State array: contents are rebuilt by INIT on every run, so it carries no reset
   always_ff @(posedge clk) begin
      case (state)
         INIT: s_mem[i_q] <= i_q;
         KSA: begin
            s_mem[i_q]   <= s_mem[ksa_j];
            s_mem[ksa_j] <= s_mem[i_q];
         end
         BYTE_WR: begin
            s_mem[i_inc]  <= s_j;
            s_mem[prga_j] <= s_i;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: plain ARC4 model plus a per-cycle write scoreboard.
// Latency: checks 514 + 2L cycles per message.
// Backpressure: pulses en while busy and expects it to be ignored.
module tb_arc4_encrypt;
   logic clk;
   logic rst_n;
   logic ct_clr;

   arc4_encrypt_if bus();

   arc4_encrypt dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [7:0] pt_mem [256];
   logic [7:0] ct_mem [256];
   logic [7:0] exp_ct [256];
   int         sb_len;
   int         sb_next;
   int         last_addr;
   int         total;
   int         bad;

   always #5 clk = ~clk;

   // synchronous pt read port and ct write port
   always @(posedge clk) begin
      bus.pt_rddata <= pt_mem[bus.pt_addr];
      if (ct_clr) begin
         for (int n = 0; n < 256; n++) ct_mem[n] <= 8'hEE;
      end else if (bus.ct_wren) begin
         ct_mem[bus.ct_addr] <= bus.ct_wrdata;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // textbook ARC4 over pt_mem (length at index 0) with a 3-byte key
   task automatic model_encrypt(input logic [23:0] k);
      int s [256];
      int kb [3];
      int a, b, t, len;
      kb[0] = int'(k[23:16]);
      kb[1] = int'(k[15:8]);
      kb[2] = int'(k[7:0]);
      for (int n = 0; n < 256; n++) s[n] = n;
      b = 0;
      for (int n = 0; n < 256; n++) begin
         b = (b + s[n] + kb[n % 3]) % 256;
         t = s[n]; s[n] = s[b]; s[b] = t;
      end
      len = int'(pt_mem[0]);
      exp_ct[0] = pt_mem[0];
      a = 0;
      b = 0;
      for (int n = 1; n <= len; n++) begin
         a = (a + 1) % 256;
         b = (b + s[a]) % 256;
         t = s[a]; s[a] = s[b]; s[b] = t;
         exp_ct[n] = pt_mem[n] ^ 8'(s[(s[a] + s[b]) % 256]);
      end
      sb_len = len;
   endtask

   task automatic set_pt_str(input string m);
      pt_mem[0] = 8'(m.len());
      for (int n = 0; n < m.len(); n++) pt_mem[n + 1] = m[n];
   endtask

   // per-cycle check of the write port against the model's ciphertext
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rdy) chk("wren_while_idle", int'(bus.ct_wren), 0);
         if (bus.ct_wren) begin
            if (sb_next > sb_len) begin
               total++;
               bad++;
               $display("FAIL extra_write: addr %0d seen after %0d expected writes", bus.ct_addr, sb_len + 1);
            end else begin
               chk("wr_addr", int'(bus.ct_addr), sb_next);
               chk("wr_data", int'(bus.ct_wrdata), int'(exp_ct[sb_next]));
            end
            last_addr = int'(bus.ct_addr);
            sb_next++;
         end
      end
   end

   // called #1 after the accepting edge
   task automatic finish_run(input logic [23:0] k, input int len);
      int cyc;
      bus.en  = 1'b0;
      bus.key = ~k;
      chk("rdy_after_accept", int'(bus.rdy), 0);
      cyc = 0;
      while (bus.rdy == 1'b0 && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         bus.en = (cyc >= 100 && cyc < 104);
      end
      bus.en = 1'b0;
      chk("latency", cyc, 514 + 2 * len);
      repeat (4) @(posedge clk);
      #1;
      chk("write_count", sb_next, len + 1);
      chk("last_addr", last_addr, len);
      for (int n = 0; n <= len; n++) chk("ct_mem", int'(ct_mem[n]), int'(exp_ct[n]));
   endtask

   task automatic start(input logic [23:0] k);
      model_encrypt(k);
      sb_next = 0;
      @(negedge clk);
      bus.key = k;
      bus.en  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_msg(input logic [23:0] k);
      start(k);
      finish_run(k, int'(pt_mem[0]));
   endtask

   initial begin
      string      msg;
      logic [71:0] kat;
      int         cyc;
      clk       = 1'b0;
      rst_n     = 1'b0;
      ct_clr    = 1'b0;
      total     = 0;
      bad       = 0;
      sb_next   = 0;
      last_addr = -1;
      bus.en    = 1'b1;
      bus.key   = 24'h000018;
      for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;

      // reset with en held, then zero-length message
      model_encrypt(24'h000018);
      repeat (3) @(negedge clk);
      chk("rst_rdy", int'(bus.rdy), 1);
      chk("rst_wren", int'(bus.ct_wren), 0);
      chk("rst_pt_addr", int'(bus.pt_addr), 0);
      chk("rst_ct_addr", int'(bus.ct_addr), 0);
      chk("rst_ct_wrdata", int'(bus.ct_wrdata), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      finish_run(24'h000018, 0);

      // model pinned to the published "Key"/"Plaintext" vector, then the DUT on it
      kat = 72'hBBF316E8D940AF0AD3;
      set_pt_str("Plaintext");
      model_encrypt(24'h4B6579);
      for (int n = 0; n < 9; n++) chk("model_kat", int'(exp_ct[n + 1]), int'(kat[71 - 8 * n -: 8]));
      run_msg(24'h4B6579);
      for (int n = 0; n < 9; n++) chk("dut_kat", int'(ct_mem[n + 1]), int'(kat[71 - 8 * n -: 8]));

      // 16-byte message, then round trip back to plaintext
      msg = "ARC4 test vector";
      set_pt_str(msg);
      run_msg(24'h1A2B3C);
      chk("ct_len", int'(ct_mem[0]), 16);
      for (int n = 1; n <= 16; n++) pt_mem[n] = ct_mem[n];
      run_msg(24'h1A2B3C);
      for (int n = 0; n < 16; n++) chk("roundtrip", int'(ct_mem[n + 1]), int'(msg[n]));

      // maximum length
      pt_mem[0] = 8'd255;
      for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
      run_msg(24'hFFFFFF);

      // abort in BYTE_WR at k=5, then rerun from scratch
      set_pt_str(msg);
      start(24'h1A2B3C);
      bus.en = 1'b0;
      cyc = 0;
      while (!(bus.ct_wren && bus.ct_addr == 8'd5) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_point_reached", int'(cyc < 2000), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_wren", int'(bus.ct_wren), 0);
      chk("abort_rdy", int'(bus.rdy), 1);
      chk("abort_ct_addr", int'(bus.ct_addr), 0);
      ct_clr = 1'b1;
      @(posedge clk);
      #1;
      ct_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_abort", int'(bus.rdy), 1);
      run_msg(24'h1A2B3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/arc4_encrypt.md
# arc4_encrypt

ARC4 encryptor that produces the length-prefixed ciphertext messages the `crack` block consumes. It reads a plaintext message from a memory read port and runs init, key scheduling and PRGA on an internal 256-byte state array. It writes the length byte and the XOR-encrypted bytes to ciphertext memory through a write port. It is the writer end of the ct memory interface and serves as a stimulus generator for `crack` on hardware and in simulation.

## Interface
Parameters: none; the key is 24-bit and the message format is fixed.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: start request, sampled only while `rdy`=1.
- `rdy` out 1: 1 = idle and able to accept `en`.
- `key` in 24: ARC4 key, latched when a start is accepted. Key byte 0 = `key[23:16]`, byte 1 = `key[15:8]`, byte 2 = `key[7:0]`.
- `pt_addr` out 8: plaintext memory address.
- `pt_rddata` in 8: plaintext data, valid exactly one cycle after `pt_addr` is driven (synchronous RAM).
- `ct_addr` out 8: ciphertext memory write address.
- `ct_wrdata` out 8: ciphertext write data.
- `ct_wren` out 1: ciphertext write strobe, one cycle per byte.

## Operation
Message format is the same in pt and ct memory:
- address 0 holds length L (0..255);
- addresses 1..L hold data bytes.

State machine (IDLE, INIT, KSA, LEN_REQ, LEN_WR, BYTE_REQ, BYTE_WR):
- IDLE: `rdy`=1. If `en`=1 at an edge, latch `key`, clear i and j, and go to INIT. `rdy` falls in the same edge.
- INIT: 256 cycles, one per index, writing S[i]=i for i=0..255.
- KSA: 256 cycles, one per i=0..255.
  - j = j + S[i] + keybyte[i mod 3], computed mod 256.
  - Swap S[i] and S[j] in the same cycle, using the new j.
  - If i==j, S is unchanged.
- LEN_REQ: drive `pt_addr`=0 and reset the PRGA counters to i=0, j=0.
- LEN_WR: capture L = `pt_rddata` and write `ct_addr`=0, `ct_wrdata`=L, `ct_wren`=1. If L=0, go to IDLE; otherwise set k=1 and go to BYTE_REQ.
- BYTE_REQ: drive `pt_addr`=k.
- BYTE_WR: for pt byte k, one PRGA step in this single cycle:
  - i = i+1; j = j + S[i];
  - swap S[i] and S[j];
  - pad = S[(S[i]+S[j]) mod 256], with pad read from the post-swap array;
  - write `ct_addr`=k, `ct_wrdata`=`pt_rddata`^pad, `ct_wren`=1.
  - If k==L, go to IDLE; otherwise increment k and go to BYTE_REQ.

Arithmetic and width rules:
- All index arithmetic is 8-bit and wraps mod 256.
- k is held in 9 bits internally so that L=255 terminates correctly.

## Timing
- Reset values:
  - `rdy`=1, `ct_wren`=0;
  - `pt_addr`=0, `ct_addr`=0, `ct_wrdata`=0;
  - state=IDLE, with i, j and k cleared.
- S contents are undefined after reset. INIT always rebuilds S before use.
- Latency from the accepting edge to `rdy`=1 is 256 + 256 + 2 + 2L cycles.
  - L=0 gives 514 cycles.
  - L=255 gives 1024 cycles.
- `ct_wren` is high only in LEN_WR and BYTE_WR, and for exactly one cycle per written byte.
- Write addresses are strictly increasing: 0, 1, ..., L.
- `en` is ignored while `rdy`=0. Holding `en` high continuously restarts encryption on the cycle after `rdy` rises. That restart overwrites ct with identical results if pt and `key` are unchanged.
- `key` changes while busy have no effect on the current message.
- Reset asserted mid-operation:
  - all outputs return to their reset values immediately (asynchronous);
  - no further ct writes occur;
  - a partially written ct memory is left as is.
- After reset is released, the block waits in IDLE for a new `en`.

## Test plan
- Reset: hold `rst_n`=0 with `en`=1, then release. Outputs must be at their reset values while in reset. After release, the start is accepted on the first edge and `rdy`=0 on the next cycle.
- Zero-length message: pt[0]=0, `key`=24'h000018. Exactly one write (ct[0]=0) must occur, and `rdy` returns to 1 exactly 514 cycles after acceptance.
- Known-answer check: L=16, pt="ARC4 test vector", `key`=24'h1A2B3C.
  - ct[0] must be 16.
  - ct[1..16] must match a behavioural ARC4 model in the bench byte-for-byte.
  - Exactly 17 `ct_wren` pulses in address order; `rdy` returns after 546 cycles.
- Round trip: feed the ct produced with `key`=24'h1A2B3C back as pt with the same key. The output must equal the original plaintext. Also run the result through `crack` with a key space containing 24'h1A2B3C; `key_valid`=1 and `key`=24'h1A2B3C are required.
- Maximum length: L=255, random bytes, `key`=24'hFFFFFF. 256 writes must occur, with the final write at `ct_addr`=255. The block must terminate (no wrap to address 0) and `rdy` returns after 1024 cycles.
- Abort and restart: assert `rst_n`=0 while in BYTE_WR at k=5, then release and restart with the same key. `ct_wren` must drop immediately, and the second run must produce output identical to an uninterrupted run.
